// File: rtl/mem_arbiter_if.sv
// Requester and physical-memory bus shared by mem_arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if;
    logic        i_read;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_addr;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;
    logic        proto_err;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
               pmem_wdata, proto_err
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr,
               pmem_wdata, proto_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single physical memory port,
// with optional round-robin fairness and a sticky read+write protocol error flag.
module mem_arbiter #(
    parameter int RR_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t state;
    state_t state_nxt;
    logic   last_d;
    logic   cur_d;
    logic   grant_i;
    logic   grant_d;
    logic   d_req;
    logic   pick_d;

    assign d_req  = bus.d_read | bus.d_write;
    // Only consulted when both ports request at once.
    assign pick_d = (RR_EN == 0) ? 1'b1 : !last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!bus.i_read || pick_d)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (bus.i_read) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: if (bus.pmem_resp) state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    assign bus.i_resp = (state == DONE) && !cur_d;
    assign bus.d_resp = (state == DONE) &&  cur_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pmem_read  <= 1'b0;
            bus.pmem_write <= 1'b0;
            bus.pmem_addr  <= 16'h0000;
            bus.pmem_wdata <= 16'h0000;
            bus.i_rdata    <= 16'h0000;
            bus.d_rdata    <= 16'h0000;
            bus.proto_err  <= 1'b0;
            last_d         <= 1'b0;
            cur_d          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        bus.pmem_addr  <= bus.d_addr;
                        bus.pmem_wdata <= bus.d_wdata;
                        // A simultaneous read+write request is treated as a write.
                        bus.pmem_write <= bus.d_write;
                        bus.pmem_read  <= bus.d_read & ~bus.d_write;
                        if (bus.d_read && bus.d_write) bus.proto_err <= 1'b1;
                        cur_d  <= 1'b1;
                        last_d <= 1'b1;
                    end else if (grant_i) begin
                        bus.pmem_addr  <= bus.i_addr;
                        bus.pmem_read  <= 1'b1;
                        bus.pmem_write <= 1'b0;
                        cur_d  <= 1'b0;
                        last_d <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (bus.pmem_resp) begin
                        bus.i_rdata    <= bus.pmem_rdata;
                        bus.pmem_read  <= 1'b0;
                        bus.pmem_write <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (bus.pmem_resp) begin
                        if (!bus.pmem_write) bus.d_rdata <= bus.pmem_rdata;
                        bus.pmem_read  <= 1'b0;
                        bus.pmem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter, each with a
// behavioural memory; expected responses are queued at issue and popped by a monitor.
module tb_mem_arbiter;
    typedef struct packed {
        logic        is_d;
        logic [15:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   resp_cnt [2] = '{0, 0};
    int   resp_cyc [2] = '{0, 0};
    int   dly      [2] = '{1, 1};
    exp_t exp_q    [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if bus [2] ();

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_resp(input int g, input int target, input string name);
        int n;
        n = 0;
        while (resp_cnt[g] < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (resp_cnt[g] < target) begin
            errors++;
            $display("FAIL %0s: timeout with %0d responses, expected %0d", name, resp_cnt[g], target);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        mem_arbiter #(.RR_EN(g == 0 ? 1 : 0)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );

        // Memory model: answers dly cycles after seeing a command; writes return junk data.
        initial begin : model
            logic [15:0] mem [256];
            logic [15:0] a;
            logic        w;
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
            mem[8'h40] = 16'h1234;
            mem[8'h11] = 16'hD011;
            mem[8'h22] = 16'hA022;
            bus[g].pmem_resp  = 1'b0;
            bus[g].pmem_rdata = 16'h0000;
            forever begin
                @(negedge clk);
                if (bus[g].pmem_read || bus[g].pmem_write) begin
                    a = bus[g].pmem_addr;
                    w = bus[g].pmem_write;
                    if (w) mem[a[7:0]] = bus[g].pmem_wdata;
                    repeat (dly[g]) @(negedge clk);
                    bus[g].pmem_resp  = 1'b1;
                    bus[g].pmem_rdata = w ? 16'hDEAD : mem[a[7:0]];
                    @(negedge clk);
                    bus[g].pmem_resp  = 1'b0;
                    bus[g].pmem_rdata = 16'h0000;
                end
            end
        end

        always @(negedge clk) begin : monitor
            exp_t e;
            if (bus[g].i_resp && bus[g].d_resp) check("resp_overlap", 32'd1, 32'd0);
            if (bus[g].i_resp || bus[g].d_resp) begin
                resp_cnt[g]++;
                resp_cyc[g] = cyc;
                if (exp_q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: dut %0d got i_resp=%b d_resp=%b, expected none",
                             g, bus[g].i_resp, bus[g].d_resp);
                end else begin
                    e = exp_q[g].pop_front();
                    check("resp_port_is_d", {31'b0, bus[g].d_resp}, {31'b0, e.is_d});
                    check("resp_rdata", e.is_d ? bus[g].d_rdata : bus[g].i_rdata, e.data);
                end
            end
        end
    end

    initial begin
        int t0;
        bus[0].i_read = 0; bus[0].i_addr = 0; bus[0].d_read = 0; bus[0].d_write = 0;
        bus[0].d_addr = 0; bus[0].d_wdata = 0;
        bus[1].i_read = 0; bus[1].i_addr = 0; bus[1].d_read = 0; bus[1].d_write = 0;
        bus[1].d_addr = 0; bus[1].d_wdata = 0;

        repeat (2) @(negedge clk);
        check("rst_pmem_read",  bus[0].pmem_read,  0);
        check("rst_pmem_write", bus[0].pmem_write, 0);
        check("rst_pmem_addr",  bus[0].pmem_addr,  16'h0000);
        check("rst_proto_err",  bus[0].proto_err,  0);
        check("rst_i_resp",     bus[0].i_resp,     0);
        check("rst_d_rdata",    bus[0].d_rdata,    16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin with both ports requesting: D, I, D, I.
        bus[0].d_addr = 16'h0011; bus[0].i_addr = 16'h0022;
        bus[0].d_read = 1; bus[0].i_read = 1;
        exp_q[0].push_back({1'b1, 16'hD011});
        exp_q[0].push_back({1'b0, 16'hA022});
        exp_q[0].push_back({1'b1, 16'hD011});
        exp_q[0].push_back({1'b0, 16'hA022});
        wait_resp(0, 4, "rr_four");
        bus[0].d_read = 0; bus[0].i_read = 0;
        @(negedge clk);

        // Instruction read, memory answers after 2 cycles.
        dly[0] = 2;
        bus[0].i_addr = 16'h0040; bus[0].i_read = 1;
        exp_q[0].push_back({1'b0, 16'h1234});
        @(posedge clk); #1;
        check("i_cmd_read",  bus[0].pmem_read,  1);
        check("i_cmd_write", bus[0].pmem_write, 0);
        check("i_cmd_addr",  bus[0].pmem_addr,  16'h0040);
        wait_resp(0, 5, "i_read");
        bus[0].i_read = 0;
        @(negedge clk);

        // Minimum latency with a one-cycle memory.
        dly[0] = 1;
        t0 = cyc;
        bus[0].i_addr = 16'h0022; bus[0].i_read = 1;
        exp_q[0].push_back({1'b0, 16'hA022});
        wait_resp(0, 6, "latency_read");
        bus[0].i_read = 0;
        check("min_latency", resp_cyc[0] - t0, 3);
        @(negedge clk);

        // Data write must leave d_rdata at its previous value.
        bus[0].d_addr = 16'h2000; bus[0].d_wdata = 16'hBEEF; bus[0].d_write = 1;
        exp_q[0].push_back({1'b1, 16'hD011});
        @(posedge clk); #1;
        check("w_cmd_write", bus[0].pmem_write, 1);
        check("w_cmd_read",  bus[0].pmem_read,  0);
        check("w_cmd_addr",  bus[0].pmem_addr,  16'h2000);
        check("w_cmd_wdata", bus[0].pmem_wdata, 16'hBEEF);
        bus[0].d_wdata = 16'h0000;
        #2 check("w_cmd_hold", bus[0].pmem_wdata, 16'hBEEF);
        wait_resp(0, 7, "d_write");
        bus[0].d_write = 0;
        @(negedge clk);

        // Read back the written word.
        bus[0].d_read = 1;
        exp_q[0].push_back({1'b1, 16'hBEEF});
        wait_resp(0, 8, "d_readback");
        bus[0].d_read = 0;
        check("proto_err_clear", bus[0].proto_err, 0);
        @(negedge clk);

        // Read and write together: write wins, proto_err sticks.
        bus[0].d_addr = 16'h0010; bus[0].d_wdata = 16'h5A5A;
        bus[0].d_read = 1; bus[0].d_write = 1;
        exp_q[0].push_back({1'b1, 16'hBEEF});
        @(posedge clk); #1;
        check("rw_cmd_write", bus[0].pmem_write, 1);
        check("rw_cmd_read",  bus[0].pmem_read,  0);
        check("rw_cmd_addr",  bus[0].pmem_addr,  16'h0010);
        wait_resp(0, 9, "d_rw");
        bus[0].d_read = 0; bus[0].d_write = 0;
        check("proto_err_set", bus[0].proto_err, 1);
        @(negedge clk);
        bus[0].i_addr = 16'h0040; bus[0].i_read = 1;
        exp_q[0].push_back({1'b0, 16'h1234});
        wait_resp(0, 10, "i_after_err");
        bus[0].i_read = 0;
        check("proto_err_sticky", bus[0].proto_err, 1);
        @(negedge clk);

        // Reset in BUSY_D, then a late memory response.
        dly[0] = 5;
        bus[0].d_addr = 16'h0030; bus[0].d_read = 1;
        @(posedge clk); #1;
        check("busy_cmd_read", bus[0].pmem_read, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; bus[0].d_read = 0;
        #1;
        check("arst_pmem_read",  bus[0].pmem_read, 0);
        check("arst_pmem_addr",  bus[0].pmem_addr, 16'h0000);
        check("arst_proto_err",  bus[0].proto_err, 0);
        check("arst_d_rdata",    bus[0].d_rdata,   16'h0000);
        check("arst_i_rdata",    bus[0].i_rdata,   16'h0000);
        check("arst_d_resp",     bus[0].d_resp,    0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("late_resp_pmem_read", bus[0].pmem_read, 0);
        check("late_resp_count", resp_cnt[0], 10);
        dly[0] = 1;
        bus[0].i_addr = 16'h0040; bus[0].i_read = 1;
        exp_q[0].push_back({1'b0, 16'h1234});
        wait_resp(0, 11, "i_after_reset");
        bus[0].i_read = 0;
        @(negedge clk);

        // Fixed priority: the data port wins while it keeps requesting.
        bus[1].d_addr = 16'h0011; bus[1].i_addr = 16'h0022;
        bus[1].d_read = 1; bus[1].i_read = 1;
        for (int k = 0; k < 4; k++) exp_q[1].push_back({1'b1, 16'hD011});
        wait_resp(1, 4, "fixed_four");
        bus[1].d_read = 0;
        exp_q[1].push_back({1'b0, 16'hA022});
        wait_resp(1, 5, "fixed_i_last");
        bus[1].i_read = 0;
        repeat (3) @(negedge clk);

        check("queue0_empty", exp_q[0].size(), 0);
        check("queue1_empty", exp_q[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset (clk, rst_n).
REQ-002 The module SHALL have parameter RR_EN, default 1: 1 = round-robin when both ports request; 0 = data port always wins.
REQ-003 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous reset, active low.
REQ-005 The module SHALL have port i_read, input, 1 bit: instruction-port read request, held until i_resp.
REQ-006 The module SHALL have port i_addr, input, 16 bits: instruction-port word address.
REQ-007 The module SHALL have port i_rdata, output, 16 bits: instruction-port read data, valid while i_resp.
REQ-008 The module SHALL have port i_resp, output, 1 bit: instruction-port completion, one-cycle pulse.
REQ-009 The module SHALL have ports d_read and d_write, input, 1 bit each: data-port requests, held until d_resp.
REQ-010 The module SHALL have ports d_addr and d_wdata, input, 16 bits each: data-port address and write data.
REQ-011 The module SHALL have port d_rdata, output, 16 bits: data-port read data, valid while d_resp.
REQ-012 The module SHALL have port d_resp, output, 1 bit: data-port completion, one-cycle pulse.
REQ-013 The module SHALL have ports pmem_read and pmem_write, output, 1 bit each: physical memory command.
REQ-014 The module SHALL have ports pmem_addr and pmem_wdata, output, 16 bits each: registered physical address and write data.
REQ-015 The module SHALL have port pmem_rdata, input, 16 bits: physical read data, valid with pmem_resp.
REQ-016 The module SHALL have port pmem_resp, input, 1 bit: physical completion, one-cycle pulse, arriving 1..N cycles after command.
REQ-017 The module SHALL have port proto_err, output, 1 bit: sticky flag set when d_read and d_write are both sampled high at grant.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, BUSY_I, BUSY_D, DONE.
REQ-019 In IDLE with no request pending, the FSM SHALL remain in IDLE and all commands SHALL stay low.
REQ-020 In IDLE with exactly one port requesting, the FSM SHALL grant that port: BUSY_I for i_read; BUSY_D for d_read or d_write.
REQ-021 In IDLE with both ports requesting and RR_EN=1, the FSM SHALL grant the port not granted most recently; the last-grant flag resets to "I", so the data port wins first.
REQ-022 In IDLE with both ports requesting and RR_EN=0, the FSM SHALL always grant the data port.
REQ-023 At the grant edge, the module SHALL register the granted address, write data and operation into pmem_addr, pmem_wdata, pmem_read and pmem_write, so the command is visible one cycle after the request is sampled.
REQ-024 The module SHALL hold the command outputs stable for the whole BUSY state, independent of later requester input changes.
REQ-025 If d_read and d_write are both high at grant, the module SHALL perform a write and set proto_err; proto_err clears only on reset.
REQ-026 In BUSY_x, when pmem_resp is high, the module SHALL capture pmem_rdata into x_rdata, deassert pmem_read and pmem_write, and go to DONE at the same edge.
REQ-027 In DONE, the module SHALL assert the matching x_resp for exactly one cycle, then go to IDLE with no arbitration that cycle; this lets the requester drop or replace its request.
REQ-028 i_rdata and d_rdata SHALL hold their last captured value until the next completion on the same port; a write completion SHALL NOT change d_rdata.
REQ-029 Minimum request-to-resp latency SHALL be 3 cycles when pmem_resp arrives 1 cycle after the command.
REQ-030 A pmem_resp in IDLE or DONE SHALL be ignored.
REQ-031 i_resp and d_resp SHALL never be asserted in the same cycle.

Reset
REQ-032 Asserting rst_n low SHALL immediately force state IDLE; pmem_read, pmem_write, i_resp, d_resp and proto_err to 0; pmem_addr, pmem_wdata, i_rdata and d_rdata to 16'h0000; and the last-grant flag to "I".
REQ-033 Reset during BUSY SHALL abandon the transaction without any resp pulse; a late pmem_resp after reset SHALL be ignored.

Verification
REQ-034 Scenario: i_read, i_addr=16'h0040, memory returns 16'h1234 after 2 cycles -> pmem_read high with pmem_addr=16'h0040, then i_resp pulses one cycle with i_rdata=16'h1234.
REQ-035 Scenario: d_write, d_addr=16'h2000, d_wdata=16'hBEEF -> pmem_write high with pmem_wdata=16'hBEEF, then d_resp pulses; d_rdata unchanged.
REQ-036 Scenario: RR_EN=1, both ports requesting continuously for 4 transactions -> grant order D, I, D, I, with no overlapping resp pulses.
REQ-037 Scenario: RR_EN=0, both ports requesting continuously -> the data port is granted every time; i_resp never pulses while d_read stays high.
REQ-038 Scenario: d_read and d_write both high, d_addr=16'h0010 -> write performed, proto_err=1 and sticky until rst_n low.
REQ-039 Scenario: rst_n pulsed low during BUSY_D, then pmem_resp arrives -> all outputs at reset values, no d_resp, and IDLE accepts a new i_read.
